// File: rtl/hazard_fwd_scoreboard.sv
// ID-stage hazard and forwarding unit with a single-entry MUL/DIV scoreboard.
// Optional stall-cycle counter is built when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int RA_W       = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*RA_W-1:0]   id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_is_branch,
    input  logic [RA_W-1:0]           id_dest,
    input  logic                      id_regwrite,
    input  logic                      id_md_issue,
    input  logic [RA_W-1:0]           ex_dest,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic [RA_W-1:0]           mem_dest,
    input  logic                      mem_regwrite,
    input  logic                      mem_memread,
    input  logic [RA_W-1:0]           wb_dest,
    input  logic                      wb_regwrite,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      pc_write,
    output logic                      ifid_write,
    output logic                      ex_flush,
    output logic                      md_busy,
    output logic                      md_done,
    output logic [RA_W-1:0]           md_dest_o,
    output logic [31:0]               perf_stall_cycles
);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [3:0] MD_RELOAD = 4'(MD_LATENCY - 1);

    md_state_t            md_state;
    logic [3:0]           md_cnt;
    logic [RA_W-1:0]      md_dest_q;
    logic                 md_pending;
    logic                 md_waw;
    logic                 md_struct;
    logic                 md_accept;
    logic                 stall;
    logic                 hold;
    logic [NUM_SRC-1:0]   src_stall;
    logic [2*NUM_SRC-1:0] sel_raw;

    assign md_busy    = (md_state == MD_BUSY);
    assign md_done    = md_busy && (md_cnt == 4'd0);
    assign md_pending = md_busy && !md_done;
    assign md_dest_o  = md_dest_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [RA_W-1:0] addr;
        logic            used;
        logic            m_ex;
        logic            m_mem;
        logic            m_wb;
        logic            md_raw;
        logic            md_hit;

        assign addr   = id_src_addr[i*RA_W +: RA_W];
        assign used   = id_src_used[i];
        assign m_ex   = used && (addr == ex_dest)  && (ex_dest  != '0) && ex_regwrite;
        assign m_mem  = used && (addr == mem_dest) && (mem_dest != '0) && mem_regwrite;
        assign m_wb   = used && (addr == wb_dest)  && (wb_dest  != '0) && wb_regwrite;
        assign md_raw = used && md_pending && (addr == md_dest_q);
        assign md_hit = used && md_done && (addr == md_dest_q) && (md_dest_q != '0);

        // A load in MEM cannot be forwarded from the MEM latch; it falls through to WB/RF.
        assign src_stall[i] = (m_ex && ex_memread)
                            || (id_is_branch && m_ex)
                            || (id_is_branch && m_mem && mem_memread)
                            || md_raw;

        assign sel_raw[2*i +: 2] = md_hit                 ? 2'b11 :
                                   (m_mem && !mem_memread) ? 2'b10 :
                                   m_wb                    ? 2'b01 : 2'b00;
    end

    assign md_waw    = id_regwrite && (id_dest != '0) && md_pending && (id_dest == md_dest_q);
    assign md_struct = id_md_issue && md_pending;
    assign stall     = (|src_stall) || md_waw || md_struct;

    assign hold       = stall || !rst_n;
    assign pc_write   = !hold;
    assign ifid_write = !hold;
    assign ex_flush   = hold;
    assign fwd_sel    = hold ? '0 : sel_raw;

    // MD issue handshake: id_md_issue is valid, !stall is ready; the op is taken
    // on the clock edge where both hold. A zero destination is taken but not tracked.
    assign md_accept = id_md_issue && !stall && (id_dest != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state  <= MD_IDLE;
            md_cnt    <= 4'd0;
            md_dest_q <= '0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (md_accept) begin
                        md_state  <= MD_BUSY;
                        md_cnt    <= MD_RELOAD;
                        md_dest_q <= id_dest;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt != 4'd0) begin
                        md_cnt <= md_cnt - 4'd1;
                    end else if (md_accept) begin
                        md_cnt    <= MD_RELOAD;
                        md_dest_q <= id_dest;
                    end else begin
                        md_state  <= MD_IDLE;
                        md_dest_q <= '0;
                    end
                end
                default: begin
                    md_state <= MD_IDLE;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= 32'd0;
        end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule
